// File: rtl/cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_arbiter
// Purpose  : Round-robin arbiter sharing one external memory bus between the
//            CPU path (m0) and a secondary master (m1), with a ready timeout.
// Revision : 1.0
// ============================================================================
module cpu_bus_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_done,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_done,
    output logic              m1_err,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,

    output logic              owner,
    output logic              busy
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next;

    logic               r_owner;
    logic               r_last_owner;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;
    logic [DATA_W-1:0]  r_m0_rdata;
    logic [DATA_W-1:0]  r_m1_rdata;

    logic               w_req_any;
    logic               w_grant_sel;
    logic               w_cnt_last;

    // On a tie the master that did not own the bus last time wins.
    assign w_req_any   = m0_req | m1_req;
    assign w_grant_sel = (m0_req & m1_req) ? ~r_last_owner : m1_req;
    assign w_cnt_last  = (r_cnt == c_CNT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_ready || w_cnt_last) begin
                    w_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction datapath: latched request, timeout counter, read data
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_owner      <= 1'b1;
            r_last_owner <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_owner <= w_grant_sel;
                        r_we    <= w_grant_sel ? m1_we    : m0_we;
                        r_addr  <= w_grant_sel ? m1_addr  : m0_addr;
                        r_wdata <= w_grant_sel ? m1_wdata : m0_wdata;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    // A ready on the last allowed cycle still counts as success.
                    if (mem_ready) begin
                        r_err <= 1'b0;
                        if (!r_we) begin
                            if (r_owner) begin
                                r_m1_rdata <= mem_rdata;
                            end else begin
                                r_m0_rdata <= mem_rdata;
                            end
                        end
                    end else if (w_cnt_last) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_FINISH: begin
                    r_last_owner <= r_owner;
                end
                default: begin
                    r_err <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode (registered state only, no path from m*_req)
    // ------------------------------------------------------------------
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        m0_done   = 1'b0;
        m0_err    = 1'b0;
        m1_done   = 1'b0;
        m1_err    = 1'b0;
        m0_rdata  = r_m0_rdata;
        m1_rdata  = r_m1_rdata;
        owner     = r_owner;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_ACCESS: begin
                mem_en = 1'b1;
                mem_we = r_we;
            end
            S_FINISH: begin
                m0_done = ~r_owner;
                m0_err  = ~r_owner & r_err;
                m1_done = r_owner;
                m1_err  = r_owner & r_err;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_bus_arbiter
// Purpose  : Directed self-checking bench with a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_cpu_bus_arbiter;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [7:0] m0_rdata, m1_rdata;
    logic       m0_done, m0_err, m1_done, m1_err;
    logic       mem_en, mem_we, mem_ready;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       owner, busy;

    always #5 clk = ~clk;

    cpu_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .owner(owner), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: one transaction in flight, an age in bus
    // cycles, and a one-cycle completion report afterwards.
    // ------------------------------------------------------------------
    bit         mv = 1'b0;
    bit         e_act, e_fin, e_err, e_own, e_last, e_we;
    logic [7:0] e_addr, e_wdata;
    logic [7:0] e_rd [2];
    int         e_age;

    always @(posedge clk) begin
        if (!reset) begin
            mv = 1'b1; e_act = 1'b0; e_fin = 1'b0; e_err = 1'b0;
            e_own = 1'b1; e_last = 1'b1; e_we = 1'b0;
            e_addr = 8'h00; e_wdata = 8'h00; e_age = 0;
            e_rd[0] = 8'h00; e_rd[1] = 8'h00;
        end else if (mv) begin
            if (e_fin) begin
                e_fin  = 1'b0;
                e_last = e_own;
            end else if (e_act) begin
                e_age++;
                if (mem_ready) begin
                    if (!e_we) e_rd[e_own] = mem_rdata;
                    e_err = 1'b0; e_act = 1'b0; e_fin = 1'b1;
                end else if (e_age == TMO) begin
                    e_err = 1'b1; e_act = 1'b0; e_fin = 1'b1;
                end
            end else if (m0_req || m1_req) begin
                e_own   = (m0_req && m1_req) ? !e_last : m1_req;
                e_we    = e_own ? m1_we    : m0_we;
                e_addr  = e_own ? m1_addr  : m0_addr;
                e_wdata = e_own ? m1_wdata : m0_wdata;
                e_age = 0; e_act = 1'b1; e_err = 1'b0;
            end
        end
    end

    // Per-cycle compare plus completion log
    int done_log [$];
    always @(negedge clk) begin
        if (mv) begin
            chk("mem_en",    mem_en,    e_act);
            chk("mem_we",    mem_we,    e_act & e_we);
            chk("mem_addr",  mem_addr,  e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("m0_done",   m0_done,   e_fin & !e_own);
            chk("m1_done",   m1_done,   e_fin & e_own);
            chk("m0_err",    m0_err,    e_fin & !e_own & e_err);
            chk("m1_err",    m1_err,    e_fin & e_own & e_err);
            chk("m0_rdata",  m0_rdata,  e_rd[0]);
            chk("m1_rdata",  m1_rdata,  e_rd[1]);
            chk("owner",     owner,     e_own);
            chk("busy",      busy,      e_act | e_fin);
            if (m0_done) done_log.push_back(0);
            if (m1_done) done_log.push_back(1);
        end
    end

    // Memory responder: 0 never ready, 1 immediate, 2 on cycle rdy_at, 3 spurious while idle
    int         rdy_mode = 0;
    int         rdy_at   = 1;
    int         acc_cyc  = 0;
    int         acc_len  = 0;
    logic [7:0] acc_addr = 8'h00;
    logic [7:0] wd_log [$];

    always @(negedge clk) begin
        if (mem_en) begin
            acc_cyc++;
            acc_addr = mem_addr;
            if (acc_cyc == 1) wd_log.push_back(mem_wdata);
            mem_ready = (rdy_mode == 1) || (rdy_mode == 2 && acc_cyc == rdy_at);
        end else begin
            if (acc_cyc > 0) acc_len = acc_cyc;
            acc_cyc   = 0;
            mem_ready = (rdy_mode == 3);
        end
    end

    task automatic wait_done(input int maxc, output int port, output logic err);
        port = -1;
        err  = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (m0_done || m1_done) begin
                port = m1_done ? 1 : 0;
                err  = m0_err | m1_err;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_done actual=no_done required=done_within_%0d", maxc);
    endtask

    task automatic wait_mem_en(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (mem_en) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_mem_en actual=idle required=mem_en_within_%0d", maxc);
    endtask

    int   p;
    logic e;
    int   nd;

    initial begin
        reset = 1'b0; mem_ready = 1'b0; mem_rdata = 8'h00;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 8'h00; m0_wdata = 8'h00;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 8'h00; m1_wdata = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_owner", owner, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 16'h0000);
        reset = 1'b1;

        // Single read
        rdy_mode = 2; rdy_at = 2; mem_rdata = 8'hA5; m0_addr = 8'h10; m0_we = 1'b0;
        @(negedge clk);
        m0_req = 1'b1;
        wait_done(20, p, e);
        m0_req = 1'b0;
        chk("t1_port", p, 0);
        chk("t1_err", e, 0);
        @(negedge clk);
        chk("t1_done_1cyc", m0_done, 0);
        @(negedge clk);
        chk("t1_m0_rdata", m0_rdata, 8'hA5);
        chk("t1_m1_rdata", m1_rdata, 8'h00);
        chk("t1_acc_len", acc_len, 2);
        chk("t1_addr", acc_addr, 8'h10);

        // Tie after reset: alternate m0,m1,m0,m1
        reset = 1'b0; @(negedge clk); reset = 1'b1;
        m0_we = 1'b1; m0_addr = 8'h01; m0_wdata = 8'h11;
        m1_we = 1'b1; m1_addr = 8'h02; m1_wdata = 8'h22;
        rdy_mode = 1;
        done_log.delete(); wd_log.delete();
        @(negedge clk);
        m0_req = 1'b1; m1_req = 1'b1;
        for (int k = 0; k < 4; k++) wait_done(10, p, e);
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_ndone", done_log.size(), 4);
        chk("t2_nwd", wd_log.size(), 4);
        if (done_log.size() == 4 && wd_log.size() == 4) begin
            chk("t2_order", {done_log[0][3:0], done_log[1][3:0], done_log[2][3:0], done_log[3][3:0]}, 16'h0101);
            chk("t2_wdata", {wd_log[0], wd_log[1], wd_log[2], wd_log[3]}, 32'h11221122);
        end

        // m1 good read, then a timed-out read that must leave rdata alone
        m1_we = 1'b0; m1_addr = 8'h40; mem_rdata = 8'h5A; rdy_mode = 1;
        @(negedge clk);
        m1_req = 1'b1;
        wait_done(20, p, e);
        m1_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("t3_pre_rdata", m1_rdata, 8'h5A);
        rdy_mode = 0; mem_rdata = 8'hFF;
        @(negedge clk);
        m1_req = 1'b1;
        wait_done(30, p, e);
        m1_req = 1'b0;
        chk("t3_port", p, 1);
        chk("t3_err", e, 1);
        repeat (2) @(negedge clk);
        chk("t3_acc_len", acc_len, TMO);
        chk("t3_m1_rdata", m1_rdata, 8'h5A);

        // Ready on the last allowed ACCESS cycle
        m0_we = 1'b0; m0_addr = 8'h50; mem_rdata = 8'h3C; rdy_mode = 2; rdy_at = TMO;
        @(negedge clk);
        m0_req = 1'b1;
        wait_done(30, p, e);
        m0_req = 1'b0;
        chk("t4_port", p, 0);
        chk("t4_err", e, 0);
        repeat (2) @(negedge clk);
        chk("t4_acc_len", acc_len, TMO);
        chk("t4_m0_rdata", m0_rdata, 8'h3C);

        // Request fields change after grant; bus keeps the latched ones
        m0_we = 1'b0; m0_addr = 8'h20; mem_rdata = 8'h77; rdy_mode = 2; rdy_at = 4;
        @(negedge clk);
        m0_req = 1'b1;
        wait_mem_en(5);
        m0_addr = 8'h30; m0_we = 1'b1; m0_wdata = 8'h99;
        wait_done(20, p, e);
        m0_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_addr", acc_addr, 8'h20);
        chk("t5_acc_len", acc_len, 4);
        chk("t5_m0_rdata", m0_rdata, 8'h77);

        // Spurious ready while idle
        rdy_mode = 3;
        nd = 0;
        repeat (4) begin
            @(negedge clk);
            if (m0_done || m1_done || busy) nd++;
        end
        chk("t5_spurious", nd, 0);
        rdy_mode = 0;
        repeat (2) @(negedge clk);

        // Reset during the 2nd ACCESS cycle of an m1 transfer
        m1_we = 1'b0; m1_addr = 8'h60;
        @(negedge clk);
        m1_req = 1'b1;
        wait_mem_en(5);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_mem_en", mem_en, 0);
        chk("t6_busy", busy, 0);
        chk("t6_m1_done", m1_done, 0);
        chk("t6_owner", owner, 1);
        reset = 1'b1; m0_we = 1'b0; m0_req = 1'b1; rdy_mode = 1;
        wait_done(10, p, e);
        m0_req = 1'b0; m1_req = 1'b0;
        chk("t6_first_grant", p, 0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
